// File: rtl/pipeline_controller_if.sv
// pipeline_controller_if: hazard inputs and stage-control outputs of the pipeline controller.
// Optional stall counter port present when PIPE_STALL_CNT_EN is defined.
`default_nettype none

interface pipeline_controller_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic             exmem_dREN;
  logic             exmem_dWEN;
  logic             exmem_pcsrc;
  logic             idex_dREN;
  logic [REG_W-1:0] idex_rt;
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             memwb_halt;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             halted;
`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`else
  logic [CNT_W-1:0] stall_cnt_unused;
  assign stall_cnt_unused = '0;
`endif

  modport master (
    input  ihit, dhit, exmem_dREN, exmem_dWEN, exmem_pcsrc,
           idex_dREN, idex_rt, ifid_rs, ifid_rt, memwb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted
`ifdef PIPE_STALL_CNT_EN
    , output stall_cnt
`endif
  );

  modport slave (
    output ihit, dhit, exmem_dREN, exmem_dWEN, exmem_pcsrc,
           idex_dREN, idex_rt, ifid_rs, ifid_rt, memwb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted
`ifdef PIPE_STALL_CNT_EN
    , input stall_cnt
`endif
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush sequencer for the five-stage pipeline (RUN/DWAIT/HALT).
// Optional saturating stall counter enabled by PIPE_STALL_CNT_EN.
`default_nettype none

module pipeline_controller #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  wire logic           CLK,
  input  wire logic           nRST,
  pipeline_controller_if.master bus
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DWAIT = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       w_dreq;
  logic       w_lu;
  logic       w_go;
  logic [4:0] w_en;
  logic [2:0] w_fl;
  logic       w_halted;

  assign w_dreq = bus.exmem_dREN | bus.exmem_dWEN;
  assign w_lu   = bus.idex_dREN && (bus.idex_rt != REG_W'(0)) &&
                  ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));

  // w_go: the cycle may advance past memory and halt checks (dreq masked once dhit ends a wait)
  always_comb begin
    w_go = 1'b0;
    w_next = r_state;
    case (r_state)
      S_RUN: begin
        if (bus.memwb_halt)
          w_next = S_HALT;
        else if (w_dreq && !bus.dhit)
          w_next = S_DWAIT;
        else
          w_go = 1'b1;
      end
      S_DWAIT: begin
        if (bus.dhit) begin
          if (bus.memwb_halt) begin
            w_next = S_HALT;
          end else begin
            w_next = S_RUN;
            w_go   = 1'b1;
          end
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RUN;
    endcase
  end

  always_comb begin
    w_en = 5'b00000;
    w_fl = 3'b000;
    if (w_go && bus.ihit) begin
      if (bus.exmem_pcsrc) begin
        w_en = 5'b11111;
        w_fl = 3'b111;
      end else if (w_lu) begin
        w_en = 5'b00111;
        w_fl = 3'b010;
      end else begin
        w_en = 5'b11111;
      end
    end
    w_halted = (r_state == S_HALT);
    if (!nRST) begin
      w_en     = 5'b00000;
      w_fl     = 3'b000;
      w_halted = 1'b0;
    end
  end

  assign {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en} = w_en;
  assign {bus.ifid_flush, bus.idex_flush, bus.exmem_flush} = w_fl;
  assign bus.halted = w_halted;

  always_ff @(posedge CLK) begin
    if (!nRST)
      r_state <= S_RUN;
    else
      r_state <= w_next;
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge CLK) begin
    if (!nRST)
      r_stall_cnt <= '0;
    else if ((r_state != S_HALT) && !w_en[4] && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign bus.stall_cnt = r_stall_cnt;
`else
  logic [CNT_W-1:0] w_cnt_unused;
  assign w_cnt_unused = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: randomized + directed scoreboard bench against a behavioural model.
`default_nettype none

module tb_pipeline_controller;
  localparam int TB_REG_W = 5;
  localparam int TB_CNT_W = 4;

  typedef struct packed {
    logic [8:0]          ctl;
    logic [TB_CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  pipeline_controller_if #(.REG_W(TB_REG_W), .CNT_W(TB_CNT_W)) bus();

  pipeline_controller #(.REG_W(TB_REG_W), .CNT_W(TB_CNT_W)) dut (
    .CLK (clk),
    .nRST(nrst),
    .bus (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // Model status: waiting on data memory, halted, stall count
  bit                  m_wait = 1'b0;
  bit                  m_halt = 1'b0;
  int                  m_cnt  = 0;

  function automatic logic [8:0] model_ctl(
    input bit rn, input bit ih, input bit dh, input bit dreq, input bit pcs,
    input bit lu, input bit hlt, input bit waiting, input bit halted_st);
    // order: pc, ifid, idex, exmem, memwb enables; ifid, idex, exmem flushes; halted
    if (!rn)                          return 9'b0;
    if (halted_st)                    return 9'b0_0000_0001;
    if (waiting && !dh)               return 9'b0;
    if (hlt)                          return 9'b0;
    if (!waiting && dreq && !dh)      return 9'b0;
    if (!ih)                          return 9'b0;
    if (pcs)                          return 9'b11111_111_0;
    if (lu)                           return 9'b00111_010_0;
    return 9'b11111_000_0;
  endfunction

  task automatic cyc(input bit rn, input bit ih, input bit dh, input bit dr, input bit dw,
                     input bit pcs, input bit idr, input int irt, input int rs, input int rt,
                     input bit hlt);
    exp_t e;
    bit   lu;
    logic [8:0] c;
    @(posedge clk);
    #1;
    nrst = rn;
    bus.ihit = ih; bus.dhit = dh; bus.exmem_dREN = dr; bus.exmem_dWEN = dw;
    bus.exmem_pcsrc = pcs; bus.idex_dREN = idr;
    bus.idex_rt = TB_REG_W'(irt); bus.ifid_rs = TB_REG_W'(rs); bus.ifid_rt = TB_REG_W'(rt);
    bus.memwb_halt = hlt;
    lu = idr && irt != 0 && (irt == rs || irt == rt);
    c = model_ctl(rn, ih, dh, dr | dw, pcs, lu, hlt, m_wait, m_halt);
    e.ctl = c;
    e.cnt = TB_CNT_W'(m_cnt);
    sb.push_back(e);
    if (!rn) begin
      m_wait = 0; m_halt = 0; m_cnt = 0;
    end else if (!m_halt) begin
      if (!c[8] && m_cnt < (1 << TB_CNT_W) - 1) m_cnt++;
      if (m_wait) begin
        if (dh) begin
          m_wait = 0;
          if (hlt) m_halt = 1;
        end
      end else if (hlt) begin
        m_halt = 1;
      end else if ((dr | dw) && !dh) begin
        m_wait = 1;
      end
    end
  endtask

  // idle-but-fetching cycle
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_cyc(input bit allow_rst);
    bit rn;
    rn = allow_rst ? ($urandom % 40 != 0) : 1'b1;
    cyc(rn, $urandom % 4 != 0, $urandom % 3 == 0, $urandom % 5 == 0, $urandom % 7 == 0,
        $urandom % 6 == 0, $urandom % 3 == 0, int'($urandom % 6), int'($urandom % 6),
        int'($urandom % 6), $urandom % 60 == 0);
  endtask

  initial begin : monitor
    exp_t  e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
               bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.halted};
        checks++;
        if (act !== e.ctl) begin
          errors++;
          $display("FAIL ctl t=%0t actual=%b expected=%b", $time, act, e.ctl);
        end
`ifdef PIPE_STALL_CNT_EN
        checks++;
        if (bus.stall_cnt !== e.cnt) begin
          errors++;
          $display("FAIL stall_cnt t=%0t actual=%0d expected=%0d", $time, bus.stall_cnt, e.cnt);
        end
`endif
      end
    end
  end

  initial begin : stim
    bus.ihit = 0; bus.dhit = 0; bus.exmem_dREN = 0; bus.exmem_dWEN = 0;
    bus.exmem_pcsrc = 0; bus.idex_dREN = 0; bus.idex_rt = '0; bus.ifid_rs = '0;
    bus.ifid_rt = '0; bus.memwb_halt = 0;
    // reset then fetch
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run(2);
    // data stall of 3 cycles, advance on dhit
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // dreq with dhit already high: no stall
    cyc(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    // load-use, then rt=0 load
    cyc(1, 1, 0, 0, 0, 0, 1, 8, 8, 3, 0);
    run(1);
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 9, 2, 9, 0);
    // branch beats load-use, and ihit freeze
    cyc(1, 1, 0, 0, 0, 1, 1, 8, 8, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 1, 8, 8, 0, 0);
    // halt with branch pending, then random inputs ignored
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) rnd_cyc(0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run(1);
    // halt arriving at the end of a data wait
    cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    run(2);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // saturate counter with 20 ihit stalls, then reset mid-DWAIT
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    run(2);
    for (int i = 0; i < 2000; i++) rnd_cyc(1);
    run(2);
    stim_done = 1'b1;
  end

  initial begin : finisher
    int guard;
    wait (stim_done);
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : timeout
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
